// File: rtl/cva6_feature_pkg.sv
// cva6_feature_pkg: core configuration type, feature indices, register map and derivation helpers
package cva6_feature_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned FLen;
    int unsigned NrCommitPorts;
    int unsigned NrIssuePorts;
    int unsigned NrWbPorts;
    logic RVF;
    logic RVD;
    logic RVC;
    logic RVB;
    logic RVV;
    logic CvxifEn;
    logic RVZiCond;
    logic ZKN;
    int unsigned ICACHE_LINE_WIDTH;
    int unsigned ICACHE_SET_ASSOC;
    int unsigned ICACHE_INDEX_WIDTH;
    int unsigned DCACHE_LINE_WIDTH;
    int unsigned DCACHE_SET_ASSOC;
    int unsigned DCACHE_INDEX_WIDTH;
    int unsigned PtLevels;
    int unsigned VpnLen;
    logic MmuPresent;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    XLEN: 32, FLen: 0, NrCommitPorts: 0, NrIssuePorts: 0, NrWbPorts: 0,
    RVF: 1'b0, RVD: 1'b0, RVC: 1'b0, RVB: 1'b0, RVV: 1'b0, CvxifEn: 1'b0, RVZiCond: 1'b0, ZKN: 1'b0,
    ICACHE_LINE_WIDTH: 0, ICACHE_SET_ASSOC: 0, ICACHE_INDEX_WIDTH: 0,
    DCACHE_LINE_WIDTH: 0, DCACHE_SET_ASSOC: 0, DCACHE_INDEX_WIDTH: 0,
    PtLevels: 0, VpnLen: 0, MmuPresent: 1'b0
  };

  localparam cva6_cfg_t cv64a6_cfg = '{
    XLEN: 64, FLen: 64, NrCommitPorts: 1, NrIssuePorts: 1, NrWbPorts: 4,
    RVF: 1'b1, RVD: 1'b1, RVC: 1'b1, RVB: 1'b0, RVV: 1'b0, CvxifEn: 1'b0, RVZiCond: 1'b0, ZKN: 1'b0,
    ICACHE_LINE_WIDTH: 128, ICACHE_SET_ASSOC: 4, ICACHE_INDEX_WIDTH: 12,
    DCACHE_LINE_WIDTH: 128, DCACHE_SET_ASSOC: 8, DCACHE_INDEX_WIDTH: 12,
    PtLevels: 3, VpnLen: 27, MmuPresent: 1'b1
  };

  localparam int unsigned FEAT_RVF      = 0;
  localparam int unsigned FEAT_RVD      = 1;
  localparam int unsigned FEAT_RVC      = 2;
  localparam int unsigned FEAT_RVB      = 3;
  localparam int unsigned FEAT_RVV      = 4;
  localparam int unsigned FEAT_CVXIF    = 5;
  localparam int unsigned FEAT_RVZICOND = 6;
  localparam int unsigned FEAT_ZKN      = 7;

  localparam int unsigned OFF_FEAT_EN = 0;
  localparam int unsigned OFF_STATUS  = 1;
  localparam int unsigned OFF_LOCK    = 2;

  typedef enum logic [1:0] {IDLE, FLUSH, WAIT, APPLY} state_e;

  function automatic logic [7:0] cap_mask(cva6_cfg_t cfg);
    cap_mask = {cfg.ZKN, cfg.RVZiCond, cfg.CvxifEn, cfg.RVV, cfg.RVB, cfg.RVC, cfg.RVD, cfg.RVF};
  endfunction

  function automatic logic [31:0] info_word(cva6_cfg_t cfg, int unsigned idx);
    info_word = idx == 0 ? {4'b0, cfg.NrWbPorts[3:0], cfg.NrIssuePorts[3:0], cfg.NrCommitPorts[3:0],
                            cfg.FLen[7:0], cfg.XLEN[7:0]} :
                idx == 1 ? {cfg.ICACHE_LINE_WIDTH[15:0], cfg.ICACHE_SET_ASSOC[7:0], cfg.ICACHE_INDEX_WIDTH[7:0]} :
                idx == 2 ? {cfg.DCACHE_LINE_WIDTH[15:0], cfg.DCACHE_SET_ASSOC[7:0], cfg.DCACHE_INDEX_WIDTH[7:0]} :
                idx == 3 ? {16'b0, cfg.PtLevels[3:0], cfg.VpnLen[7:0], 3'b0, cfg.MmuPresent} : 32'b0;
  endfunction
endpackage

// File: rtl/cva6_cfg_info_rom.sv
// cva6_cfg_info_rom: combinational word-address to read-only configuration info word
module cva6_cfg_info_rom import cva6_feature_pkg::*; #(
  parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
  parameter int unsigned NrInfoWords = 8,
  parameter int unsigned AddrW       = 4
) (
  input  logic [AddrW-1:0]        addr,
  output logic [CVA6Cfg.XLEN-1:0] info
);
  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  logic [31:0] idx;
  assign idx  = 32'(addr);
  assign info = idx < NrInfoWords ? XLEN'(info_word(CVA6Cfg, idx)) : '0;
endmodule

// File: rtl/cva6_feature_ctrl.sv
// cva6_feature_ctrl: config info words plus lockable feature-enable mask applied via flush/idle handshake
module cva6_feature_ctrl import cva6_feature_pkg::*; #(
  parameter cva6_cfg_t             CVA6Cfg       = cva6_cfg_empty,
  parameter int unsigned           NrInfoWords   = 8,
  parameter int unsigned           NrFeatures    = 8,
  parameter logic [NrFeatures-1:0] FeatRstMask   = '1,
  parameter int unsigned           IdleCycles    = 2,
  parameter int unsigned           TimeoutCycles = 1024,
  parameter int unsigned           AddrW         = $clog2(NrInfoWords + 3)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [AddrW-1:0]        addr_i,
  input  logic [CVA6Cfg.XLEN-1:0] wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [CVA6Cfg.XLEN-1:0] rdata_o,
  output logic                    err_o,
  output logic                    flush_req_o,
  input  logic                    flush_ack_i,
  input  logic                    pipeline_idle_i,
  output logic [NrFeatures-1:0]   feat_en_o,
  output logic                    feat_update_o
);
  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam int unsigned IdlW = $clog2(IdleCycles + 1);
  localparam logic [NrFeatures-1:0] CapMask = NrFeatures'(cap_mask(CVA6Cfg));
  localparam logic [AddrW-1:0] AddrFeat   = AddrW'(NrInfoWords + OFF_FEAT_EN);
  localparam logic [AddrW-1:0] AddrStatus = AddrW'(NrInfoWords + OFF_STATUS);
  localparam logic [AddrW-1:0] AddrLock   = AddrW'(NrInfoWords + OFF_LOCK);

  state_e state_q, state_d;
  logic [NrFeatures-1:0] pending_q, wmask;
  logic [TmoW-1:0] tmo_q;
  logic [IdlW-1:0] idle_q;
  logic [XLEN-1:0] info, status, rdata_d;
  logic lock_q, abort_q, busy, err_d, abort_set, timeout, idle_done;
  logic is_info, is_feat, is_status, is_lock, wr_feat, wr_lock, rd_status;
  logic wdata_unused;

  cva6_cfg_info_rom #(.CVA6Cfg(CVA6Cfg), .NrInfoWords(NrInfoWords), .AddrW(AddrW)) i_info_rom (
    .addr(addr_i),
    .info(info)
  );

  assign wdata_unused = ^wdata_i;
  assign busy      = state_q != IDLE;
  assign is_info   = 32'(addr_i) < NrInfoWords;
  assign is_feat   = addr_i == AddrFeat;
  assign is_status = addr_i == AddrStatus;
  assign is_lock   = addr_i == AddrLock;
  // Mask writes stall rather than queue, so pending_q never changes under an in-flight apply.
  assign gnt_o     = req_i & ~(we_i & is_feat & busy);
  assign wmask     = wdata_i[NrFeatures-1:0] & CapMask;
  assign wr_feat   = gnt_o & we_i & is_feat & ~lock_q;
  assign wr_lock   = gnt_o & we_i & is_lock & ~lock_q & wdata_i[0];
  assign rd_status = gnt_o & ~we_i & is_status;
  assign status    = XLEN'({pending_q, 5'b0, abort_q, lock_q, busy});
  assign rdata_d   = ~gnt_o | we_i ? '0 :
                     is_info ? info :
                     is_feat ? XLEN'(feat_en_o) :
                     is_status ? status :
                     is_lock ? XLEN'(lock_q) : '0;
  assign err_d     = gnt_o & (we_i ? ~((is_feat | is_lock) & ~lock_q) : ~(is_info | is_feat | is_status | is_lock));
  assign timeout   = tmo_q >= TmoW'(TimeoutCycles - 1);
  assign idle_done = pipeline_idle_i & (idle_q == IdlW'(IdleCycles - 1));
  assign flush_req_o = state_q == FLUSH;
  // Progress (ack or idle reached) takes priority over a same-cycle timeout.
  assign abort_set = timeout & (state_q == FLUSH & ~flush_ack_i | state_q == WAIT & ~idle_done);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = wr_feat && wmask != feat_en_o ? FLUSH : IDLE;
      FLUSH:   state_d = flush_ack_i ? WAIT : timeout ? IDLE : FLUSH;
      WAIT:    state_d = idle_done ? APPLY : timeout ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rvalid_o      <= 1'b0;
      rdata_o       <= '0;
      err_o         <= 1'b0;
      pending_q     <= '0;
      lock_q        <= 1'b0;
      abort_q       <= 1'b0;
      tmo_q         <= '0;
      idle_q        <= '0;
      feat_en_o     <= FeatRstMask & CapMask;
      feat_update_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      rvalid_o      <= gnt_o;
      rdata_o       <= rdata_d;
      err_o         <= err_d;
      pending_q     <= wr_feat ? wmask : pending_q;
      lock_q        <= lock_q | wr_lock;
      abort_q       <= abort_set | (abort_q & ~rd_status);
      tmo_q         <= state_q == FLUSH || state_q == WAIT ? tmo_q + TmoW'(1) : '0;
      idle_q        <= state_q == WAIT && pipeline_idle_i ? idle_q + IdlW'(1) : '0;
      feat_en_o     <= state_q == APPLY ? pending_q : feat_en_o;
      feat_update_o <= state_q == APPLY;
    end
  end
endmodule
